pong_frame_renderer: RTL



---
 rtl/pong_pkg.sv | 47 ++++
 rtl/pong_ball_ctrl.sv | 128 ++++++++++++
 rtl/pong_frame_renderer.sv | 81 ++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared geometry, colour constants and game-state encoding for the pong renderer.
// Coordinates are widened to 12-bit signed so that paddle-bottom sums and negative steps never wrap.
package pong_pkg;
    typedef logic signed [11:0] coord_t;

    localparam coord_t BALL    = 12'sd8;
    localparam coord_t PAD_W   = 12'sd8;
    localparam coord_t PAD_H   = 12'sd64;
    localparam coord_t PAD_L_X = 12'sd16;
    localparam coord_t PAD_R_X = 12'sd616;
    localparam coord_t SPEED   = 12'sd2;
    localparam coord_t FIELD_W = 12'sd640;
    localparam coord_t FIELD_H = 12'sd480;

    localparam int         HOLD_FRAMES = 60;
    localparam logic [5:0] HOLD_LOAD   = 6'(HOLD_FRAMES - 1);

    localparam logic [9:0] BALL_X0   = 10'd316;
    localparam logic [9:0] BALL_Y0   = 10'd236;
    localparam logic [9:0] TICK_LINE = 10'd480;
    localparam logic [9:0] NET_X0    = 10'd319;
    localparam logic [9:0] NET_X1    = 10'd320;

    localparam logic [11:0] RGB_BLACK  = 12'h000;
    localparam logic [11:0] RGB_BALL   = 12'hFFF;
    localparam logic [11:0] RGB_PADDLE = 12'h0F0;
    localparam logic [11:0] RGB_NET    = 12'h888;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_SCORED
    } game_state_t;

    function automatic coord_t to_coord(input logic [9:0] v);
        return $signed({2'b00, v});
    endfunction

    // Half-open span test: lo .. lo+size-1
    function automatic logic in_span(input coord_t p, input coord_t lo, input coord_t size);
        return (p >= lo) && (p < lo + size);
    endfunction

    function automatic logic rows_overlap(input coord_t ball_top, input coord_t pad_top);
        return (ball_top + BALL > pad_top) && (ball_top < pad_top + PAD_H);
    endfunction
endpackage

// File: rtl/pong_ball_ctrl.sv
// Ball physics and serve/play/score FSM; state advances only on frame_tick.
// Score pulses are combinational so they coincide with the frame_tick cycle.
module pong_ball_ctrl
    import pong_pkg::*;
(
    input  logic        clk_100MHz,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        serve,
    input  logic [9:0]  pad_l_y,
    input  logic [9:0]  pad_r_y,
    output logic [9:0]  ball_x,
    output logic [9:0]  ball_y,
    output game_state_t state,
    output logic        score_l,
    output logic        score_r
);
    game_state_t state_nxt;
    logic [9:0]  x_nxt, y_nxt;
    logic        dx_neg, dy_neg, dx_neg_nxt, dy_neg_nxt;
    logic [5:0]  hold, hold_nxt;
    logic        serve_pending, serve_pending_nxt;
    logic        last_r, last_r_nxt;
    coord_t      xs, ys, pl, pr, dx, dy, nx, ny;

    always_ff @(posedge clk_100MHz or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            ball_x        <= BALL_X0;
            ball_y        <= BALL_Y0;
            dx_neg        <= 1'b0;
            dy_neg        <= 1'b0;
            hold          <= '0;
            serve_pending <= 1'b0;
            last_r        <= 1'b0;
        end else begin
            state         <= state_nxt;
            ball_x        <= x_nxt;
            ball_y        <= y_nxt;
            dx_neg        <= dx_neg_nxt;
            dy_neg        <= dy_neg_nxt;
            hold          <= hold_nxt;
            serve_pending <= serve_pending_nxt;
            last_r        <= last_r_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        x_nxt             = ball_x;
        y_nxt             = ball_y;
        dx_neg_nxt        = dx_neg;
        dy_neg_nxt        = dy_neg;
        hold_nxt          = hold;
        serve_pending_nxt = serve_pending;
        last_r_nxt        = last_r;
        score_l           = 1'b0;
        score_r           = 1'b0;

        xs = to_coord(ball_x);
        ys = to_coord(ball_y);
        pl = to_coord(pad_l_y);
        pr = to_coord(pad_r_y);
        dx = dx_neg ? -SPEED : SPEED;
        dy = dy_neg ? -SPEED : SPEED;
        nx = xs + dx;
        ny = ys + dy;

        if (state == ST_IDLE && serve)
            serve_pending_nxt = 1'b1;

        if (frame_tick) begin
            case (state)
                ST_IDLE: begin
                    if (serve_pending || serve) begin
                        state_nxt         = ST_PLAY;
                        serve_pending_nxt = 1'b0;
                        dy_neg_nxt        = 1'b0;
                    end
                end
                ST_PLAY: begin
                    if (ny <= 0) begin
                        y_nxt      = '0;
                        dy_neg_nxt = 1'b0;
                    end else if (ny >= FIELD_H - BALL) begin
                        y_nxt      = 10'(FIELD_H - BALL);
                        dy_neg_nxt = 1'b1;
                    end else begin
                        y_nxt = ny[9:0];
                    end
                    // Paddle tests use the pre-move row; a hit outranks a miss.
                    if (dx_neg && nx <= PAD_L_X + PAD_W && rows_overlap(ys, pl)) begin
                        x_nxt      = 10'(PAD_L_X + PAD_W);
                        dx_neg_nxt = 1'b0;
                    end else if (nx <= 0) begin
                        score_r    = 1'b1;
                        x_nxt      = '0;
                        state_nxt  = ST_SCORED;
                        hold_nxt   = HOLD_LOAD;
                        last_r_nxt = 1'b1;
                    end else if (!dx_neg && nx + BALL >= PAD_R_X && rows_overlap(ys, pr)) begin
                        x_nxt      = 10'(PAD_R_X - BALL);
                        dx_neg_nxt = 1'b1;
                    end else if (nx >= FIELD_W - BALL) begin
                        score_l    = 1'b1;
                        x_nxt      = 10'(FIELD_W - BALL);
                        state_nxt  = ST_SCORED;
                        hold_nxt   = HOLD_LOAD;
                        last_r_nxt = 1'b0;
                    end else begin
                        x_nxt = nx[9:0];
                    end
                end
                ST_SCORED: begin
                    if (hold == '0) begin
                        state_nxt  = ST_IDLE;
                        x_nxt      = BALL_X0;
                        y_nxt      = BALL_Y0;
                        dx_neg_nxt = last_r;
                    end else begin
                        hold_nxt = hold - 6'd1;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/pong_frame_renderer.sv
// Pong top level: start-of-vblank detection, per-frame paddle capture and the
// registered pixel colour; ball motion and game flow live in pong_ball_ctrl.
module pong_frame_renderer
    import pong_pkg::*;
(
    input  logic        clk_100MHz,
    input  logic        rst,
    input  logic        clk_VGA,
    input  logic [9:0]  h_count,
    input  logic [9:0]  v_count,
    input  logic        vid_on,
    input  logic [9:0]  paddle_l_y,
    input  logic [9:0]  paddle_r_y,
    input  logic        serve,
    output logic [11:0] rgb,
    output logic [9:0]  ball_x,
    output logic [9:0]  ball_y,
    output logic        score_l,
    output logic        score_r,
    output logic        frame_tick
);
    logic [9:0]  pad_l_q, pad_r_q;
    game_state_t game_state;
    logic [11:0] pix_p0;
    logic        on_ball, on_pad, on_net;
    coord_t      hc, vc;

    // Gated by rst so no tick or score pulse can escape while reset is held.
    assign frame_tick = rst && clk_VGA && (h_count == '0) && (v_count == TICK_LINE);

    always_ff @(posedge clk_100MHz or negedge rst) begin
        if (!rst) begin
            pad_l_q <= '0;
            pad_r_q <= '0;
        end else if (frame_tick) begin
            pad_l_q <= paddle_l_y;
            pad_r_q <= paddle_r_y;
        end
    end

    pong_ball_ctrl u_ball (
        .clk_100MHz (clk_100MHz),
        .rst        (rst),
        .frame_tick (frame_tick),
        .serve      (serve),
        .pad_l_y    (pad_l_q),
        .pad_r_y    (pad_r_q),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .state      (game_state),
        .score_l    (score_l),
        .score_r    (score_r)
    );

    // Stage p0: classify the current pixel against ball, paddles and net.
    always_comb begin
        hc      = to_coord(h_count);
        vc      = to_coord(v_count);
        on_ball = in_span(hc, to_coord(ball_x), BALL) && in_span(vc, to_coord(ball_y), BALL);
        on_pad  = (in_span(hc, PAD_L_X, PAD_W) && in_span(vc, to_coord(pad_l_q), PAD_H)) ||
                  (in_span(hc, PAD_R_X, PAD_W) && in_span(vc, to_coord(pad_r_q), PAD_H));
        on_net  = ((h_count == NET_X0) || (h_count == NET_X1)) && !v_count[4];
        pix_p0  = RGB_BLACK;
        if (!vid_on)
            pix_p0 = RGB_BLACK;
        else if (on_ball && game_state != ST_SCORED)
            pix_p0 = RGB_BALL;
        else if (on_pad)
            pix_p0 = RGB_PADDLE;
        else if (on_net)
            pix_p0 = RGB_NET;
    end

    // Stage p1: colour register advances only on pixel enables.
    always_ff @(posedge clk_100MHz or negedge rst) begin
        if (!rst)
            rgb <= RGB_BLACK;
        else if (clk_VGA)
            rgb <= pix_p0;
    end
endmodule
